// File: rtl/ipml_push_packer_if.sv
// ============================================================================
// ipml_push_packer_if : narrow upstream stream plus wide FIFO write port
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ipml_push_packer_if #(
  parameter int IN_W  = 16,
  parameter int RATIO = 2
);
  localparam int OUT_W = IN_W * RATIO;

  logic             s_valid;
  logic [IN_W-1:0]  s_data;
  logic             s_last;
  logic             s_ready;
  logic [OUT_W-1:0] fifo_wr_data;
  logic             fifo_wr_en;
  logic             fifo_wr_vld;

  // Environment side: sources beats, models the FIFO.
  modport master (
    output s_valid, s_data, s_last, fifo_wr_vld,
    input  s_ready, fifo_wr_data, fifo_wr_en
  );

  // Packer side.
  modport slave (
    input  s_valid, s_data, s_last, fifo_wr_vld,
    output s_ready, fifo_wr_data, fifo_wr_en
  );
endinterface

`default_nettype wire

// File: rtl/ipml_push_packer.sv
// ============================================================================
// ipml_push_packer : packs RATIO narrow beats into one word and pushes it into
// a prefetch FIFO while it has room. Optional macro IPML_PUSH_PACKER_STALL_CNT_EN
// adds a saturating stall counter output. Revision: 1.0
// ============================================================================
`default_nettype none

module ipml_push_packer #(
  parameter int              IN_W      = 16,
  parameter int              RATIO     = 2,
  parameter bit              LSB_FIRST = 1'b1,
  parameter logic [IN_W-1:0] PAD_VAL   = '0
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  ipml_push_packer_if.slave             bus,
  output logic [$clog2(RATIO)-1:0]      lane_cnt,
  output logic                          word_pend
`ifdef IPML_PUSH_PACKER_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] c_last_lane = CNT_W'(RATIO - 1);

  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] r_out_reg;
  logic [CNT_W-1:0] r_lane_cnt;
  logic             r_out_valid;

  logic             w_s_ready;
  logic             w_wr_en;
  logic             w_accept;
  logic             w_complete;
  logic [OUT_W-1:0] w_acc_next;
  logic [OUT_W-1:0] w_word;

  assign w_s_ready  = ~r_out_valid | bus.fifo_wr_vld;
  assign w_wr_en    = r_out_valid & bus.fifo_wr_vld;
  assign w_accept   = bus.s_valid & w_s_ready;
  assign w_complete = w_accept & (bus.s_last | (r_lane_cnt == c_last_lane));

  // Both views are kept in physical bit order, so the lane mirror is applied
  // once here and the accumulator/output register never need reordering.
  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    localparam int               POS  = LSB_FIRST ? g : (RATIO - 1 - g);
    localparam logic [CNT_W-1:0] LANE = CNT_W'(g);

    logic [IN_W-1:0] w_held;
    logic            w_is_cur;
    logic            w_is_filled;

    assign w_held      = r_acc[POS*IN_W +: IN_W];
    assign w_is_cur    = (r_lane_cnt == LANE);
    assign w_is_filled = (LANE < r_lane_cnt);

    assign w_acc_next[POS*IN_W +: IN_W] = w_is_cur ? bus.s_data : w_held;
    assign w_word[POS*IN_W +: IN_W]     = w_is_cur    ? bus.s_data :
                                          w_is_filled ? w_held     : PAD_VAL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_out_reg   <= '0;
      r_lane_cnt  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_complete) begin
        r_out_reg  <= w_word;
        r_acc      <= '0;
        r_lane_cnt <= '0;
      end else if (w_accept) begin
        r_acc      <= w_acc_next;
        r_lane_cnt <= r_lane_cnt + CNT_W'(1);
      end

      // A completing word wins over a drain: it replaces the word just pushed.
      if (w_complete) begin
        r_out_valid <= 1'b1;
      end else if (w_wr_en) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef IPML_PUSH_PACKER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !bus.fifo_wr_vld && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign bus.s_ready      = w_s_ready;
  assign bus.fifo_wr_en   = w_wr_en;
  assign bus.fifo_wr_data = r_out_reg;
  assign lane_cnt         = r_lane_cnt;
  assign word_pend        = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_ipml_push_packer.sv
// Directed bench for ipml_push_packer: three instances cover RATIO=2/LSB-first,
// RATIO=4 with 16'hFFFF padding, and MS-lane-first ordering.
`default_nettype none

module tb_ipml_push_packer;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  logic [0:0] lane0;
  logic [1:0] lane1;
  logic [0:0] lane2;
  logic       pend0;
  logic       pend1;
  logic       pend2;
`ifdef IPML_PUSH_PACKER_STALL_CNT_EN
  logic [15:0] stall0;
  logic [15:0] stall1;
  logic [15:0] stall2;
`endif

  ipml_push_packer_if #(.IN_W(16), .RATIO(2)) bus0 ();
  ipml_push_packer_if #(.IN_W(16), .RATIO(4)) bus1 ();
  ipml_push_packer_if #(.IN_W(16), .RATIO(2)) bus2 ();

  ipml_push_packer #(.IN_W(16), .RATIO(2), .LSB_FIRST(1'b1), .PAD_VAL(16'h0000)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus0),
    .lane_cnt  (lane0),
    .word_pend (pend0)
`ifdef IPML_PUSH_PACKER_STALL_CNT_EN
    ,
    .stall_cnt (stall0)
`endif
  );

  ipml_push_packer #(.IN_W(16), .RATIO(4), .LSB_FIRST(1'b1), .PAD_VAL(16'hFFFF)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus1),
    .lane_cnt  (lane1),
    .word_pend (pend1)
`ifdef IPML_PUSH_PACKER_STALL_CNT_EN
    ,
    .stall_cnt (stall1)
`endif
  );

  ipml_push_packer #(.IN_W(16), .RATIO(2), .LSB_FIRST(1'b0), .PAD_VAL(16'h0000)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus2),
    .lane_cnt  (lane2),
    .word_pend (pend2)
`ifdef IPML_PUSH_PACKER_STALL_CNT_EN
    ,
    .stall_cnt (stall2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [15:0] d, input logic l);
    bus0.s_valid = v; bus0.s_data = d; bus0.s_last = l;
  endtask

  task automatic drv1(input logic v, input logic [15:0] d, input logic l);
    bus1.s_valid = v; bus1.s_data = d; bus1.s_last = l;
  endtask

  task automatic drv2(input logic v, input logic [15:0] d, input logic l);
    bus2.s_valid = v; bus2.s_data = d; bus2.s_last = l;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    drv0(0, 16'h0, 0); drv1(0, 16'h0, 0); drv2(0, 16'h0, 0);
    bus0.fifo_wr_vld = 1'b1; bus1.fifo_wr_vld = 1'b1; bus2.fifo_wr_vld = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_ready", bus0.s_ready, 1);
    chk("rst_wr_en", bus0.fifo_wr_en, 0);
    chk("rst_data",  bus0.fifo_wr_data, 0);
    chk("rst_pend",  pend0, 0);
    chk("rst_lane",  lane0, 0);
    chk("rst_data1", bus1.fifo_wr_data, 0);
    rst_n = 1'b1;
    adv();

    // Basic pack
    drv0(1, 16'h1111, 0); @(negedge clk);
    chk("b_rdy0", bus0.s_ready, 1);
    chk("b_en0", bus0.fifo_wr_en, 0);
    adv();
    drv0(1, 16'h2222, 0); @(negedge clk);
    chk("b_lane1", lane0, 1);
    chk("b_en1", bus0.fifo_wr_en, 0);
    adv();
    drv0(0, 16'h0, 0); @(negedge clk);
    chk("b_en2", bus0.fifo_wr_en, 1);
    chk("b_data", bus0.fifo_wr_data, 64'h2222_1111);
    chk("b_lane0", lane0, 0);
    adv();
    @(negedge clk);
    chk("b_en3", bus0.fifo_wr_en, 0);
    adv();

    // Streaming: a push on every even cycle from cycle 2 on
    for (int i = 0; i < 8; i++) begin
      drv0(1, 16'(i + 1), 0); @(negedge clk);
      chk("s_rdy", bus0.s_ready, 1);
      chk("s_en", bus0.fifo_wr_en, 64'((i >= 2) && (i % 2 == 0)));
      if ((i >= 2) && (i % 2 == 0))
        chk("s_data", bus0.fifo_wr_data, {32'h0, 16'(i), 16'(i - 1)});
      adv();
    end
    drv0(0, 16'h0, 0); @(negedge clk);
    chk("s_en_last", bus0.fifo_wr_en, 1);
    chk("s_data_last", bus0.fifo_wr_data, 64'h0008_0007);
    adv();
    @(negedge clk);
    chk("s_en_idle", bus0.fifo_wr_en, 0);
    adv();

    // Backpressure: FIFO full for 10 cycles with a word pending
    bus0.fifo_wr_vld = 1'b0;
    drv0(1, 16'hAAAA, 0); @(negedge clk);
    chk("bp_rdy0", bus0.s_ready, 1);
    adv();
    drv0(1, 16'hBBBB, 0); @(negedge clk);
    chk("bp_rdy1", bus0.s_ready, 1);
    chk("bp_lane1", lane0, 1);
    adv();
    drv0(1, 16'hCCCC, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_rdy_low", bus0.s_ready, 0);
      chk("bp_pend", pend0, 1);
      chk("bp_en_low", bus0.fifo_wr_en, 0);
      chk("bp_hold", bus0.fifo_wr_data, 64'hBBBB_AAAA);
      chk("bp_lane_frz", lane0, 0);
      adv();
    end
    bus0.fifo_wr_vld = 1'b1; @(negedge clk);
    chk("bp_rdy_rel", bus0.s_ready, 1);
    chk("bp_en_rel", bus0.fifo_wr_en, 1);
    chk("bp_data_rel", bus0.fifo_wr_data, 64'hBBBB_AAAA);
`ifdef IPML_PUSH_PACKER_STALL_CNT_EN
    chk("stall_cnt", stall0, 10);
`endif
    adv();
    drv0(1, 16'hDDDD, 0); @(negedge clk);
    chk("bp_en_gap", bus0.fifo_wr_en, 0);
    chk("bp_lane_c", lane0, 1);
    chk("bp_pend_gap", pend0, 0);
    adv();
    drv0(0, 16'h0, 0); @(negedge clk);
    chk("bp_en2", bus0.fifo_wr_en, 1);
    chk("bp_data2", bus0.fifo_wr_data, 64'hDDDD_CCCC);
    adv();
    @(negedge clk);
    chk("bp_en_idle", bus0.fifo_wr_en, 0);
    adv();

    // Back-to-back single-beat flushes: drain and completion in the same cycle
    drv0(1, 16'h3333, 1); @(negedge clk);
    chk("sl_en0", bus0.fifo_wr_en, 0);
    adv();
    drv0(1, 16'h4444, 1); @(negedge clk);
    chk("sl_en1", bus0.fifo_wr_en, 1);
    chk("sl_data1", bus0.fifo_wr_data, 64'h0000_3333);
    adv();
    drv0(0, 16'h0, 0); @(negedge clk);
    chk("sl_en2", bus0.fifo_wr_en, 1);
    chk("sl_data2", bus0.fifo_wr_data, 64'h0000_4444);
    adv();
    @(negedge clk);
    chk("sl_en3", bus0.fifo_wr_en, 0);
    adv();

    // s_last without s_valid is ignored, then reset mid-word
    drv0(1, 16'h7777, 0); adv();
    drv0(0, 16'h0, 1); @(negedge clk);
    chk("ign_lane", lane0, 1);
    adv();
    drv0(0, 16'h0, 0); @(negedge clk);
    chk("ign_lane2", lane0, 1);
    chk("ign_en", bus0.fifo_wr_en, 0);
    rst_n = 1'b0;
    #1;
    chk("mr_en", bus0.fifo_wr_en, 0);
    chk("mr_lane", lane0, 0);
    chk("mr_rdy", bus0.s_ready, 1);
    adv();
    rst_n = 1'b1;
    adv();
    drv0(1, 16'h5555, 0); @(negedge clk);
    chk("mr_lane0", lane0, 0);
    adv();
    drv0(1, 16'h6666, 0); @(negedge clk);
    chk("mr_lane1", lane0, 1);
    adv();
    drv0(0, 16'h0, 0); @(negedge clk);
    chk("mr_en_push", bus0.fifo_wr_en, 1);
    chk("mr_data", bus0.fifo_wr_data, 64'h6666_5555);
    adv();

    // RATIO=4: early flush with padding, then a full word
    drv1(1, 16'h0A0A, 0); adv();
    drv1(1, 16'h0B0B, 1); @(negedge clk);
    chk("ef_lane1", lane1, 1);
    adv();
    drv1(0, 16'h0, 0); @(negedge clk);
    chk("ef_en", bus1.fifo_wr_en, 1);
    chk("ef_data", bus1.fifo_wr_data, 64'hFFFF_FFFF_0B0B_0A0A);
    chk("ef_lane0", lane1, 0);
    adv();
    @(negedge clk);
    chk("ef_en_idle", bus1.fifo_wr_en, 0);
    adv();
    for (int i = 0; i < 4; i++) begin
      drv1(1, 16'(i + 1), 0); @(negedge clk);
      chk("r4_lane", lane1, 64'(i));
      chk("r4_en", bus1.fifo_wr_en, 0);
      adv();
    end
    drv1(0, 16'h0, 0); @(negedge clk);
    chk("r4_en_push", bus1.fifo_wr_en, 1);
    chk("r4_data", bus1.fifo_wr_data, 64'h0004_0003_0002_0001);
    adv();

    // MS-lane-first ordering
    drv2(1, 16'h1111, 0); adv();
    drv2(1, 16'h2222, 0); adv();
    drv2(0, 16'h0, 0); @(negedge clk);
    chk("msb_en", bus2.fifo_wr_en, 1);
    chk("msb_data", bus2.fifo_wr_data, 64'h1111_2222);
    adv();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
